// File: rtl/uart_rx_fsm.sv
// UART receiver: 16x oversampled 8-bit frames (start, 8 data LSB first, parity, stop).
// Delivers the byte with a one-cycle valid strobe and held parity/framing error flags.
module uart_rx_fsm #(
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e     state_q, state_d;
  logic       rx_meta_q, rx_s_q, rx_d_q;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic       perr_q, perr_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_d_q       <= 1'b1;
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      sr_q         <= '0;
      perr_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_d_q       <= rx_s_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      sr_q         <= sr_d;
      perr_q       <= perr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q + 4'd1;
    bit_d        = bit_q;
    sr_d         = sr_q;
    perr_d       = perr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    // Disable wins over every state so a partial frame never touches the outputs.
    if (!rx_en) begin
      state_d = IDLE;
      tick_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tick_d = '0;
          if (rx_d_q && !rx_s_q) begin
            state_d = START;
          end
        end
        START: begin
          if (tick_q == 4'd7) begin
            if (!rx_s_q) begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (tick_q == 4'd15) begin
            sr_d  = {rx_s_q, sr_q[7:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (tick_q == 4'd15) begin
            perr_d  = (^sr_q) ^ rx_s_q ^ PARITY_ODD;
            state_d = STOP;
          end
        end
        STOP: begin
          if (tick_q == 4'd15) begin
            data_out_d   = sr_q;
            parity_err_d = perr_q;
            frame_err_d  = ~rx_s_q;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
